pwm_duty_sequencer: RTL and testbench

//   Upstream stage of the LED PWM comparator: generates the 8-bit duty value the comparator checks its free-running counter against.

---
 rtl/pwm_duty_sequencer.sv | 156 +++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sequencer.sv
// Duty-value source for the LED PWM comparator: debounced manual stepping or
// automatic breathing, with the output only allowed to move on PWM period boundaries.
module pwm_duty_sequencer #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int STEP            = 16,
  parameter int BREATHE_DIV     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       mode_auto,
  input  logic       period_start,
  output logic [7:0] duty,
  output logic       duty_upd,
  output logic [1:0] state
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BR_W = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [BR_W-1:0] BR_LAST = BR_W'(BREATHE_DIV - 1);
  localparam logic [BR_W-1:0] BR_ONE  = BR_W'(1);
  localparam logic [8:0]      STEP9   = 9'(STEP);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [8:0] s;
    s = {1'b0, v} + STEP9;
    return (s > 9'd255) ? 8'd255 : s[7:0];
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    logic [8:0] s;
    s = {1'b0, v} - STEP9;
    return ({1'b0, v} < STEP9) ? 8'd0 : s[7:0];
  endfunction

  // bit 0 = up, bit 1 = down, bit 2 = mode
  logic [2:0]      sync_p0;
  logic [2:0]      sync_p1;
  logic            lvl     [2];
  logic            evt     [2];
  logic [DB_W-1:0] cnt     [2];
  state_t          fsm;
  logic [7:0]      target;
  logic [BR_W-1:0] brc;
  logic [7:0]      inc_t;
  logic [7:0]      dec_t;
  logic            mode_s;

  assign inc_t  = sat_inc(target);
  assign dec_t  = sat_dec(target);
  assign mode_s = sync_p1[2];
  assign state  = fsm;

  // Stage p0/p1: two-flop synchronizers for the raw pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {mode_auto, btn_dn, btn_up};
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing clocks;
  // a rising acceptance emits a one-cycle press event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        lvl[i] <= 1'b0;
        evt[i] <= 1'b0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        evt[i] <= 1'b0;
        if (sync_p1[i] != lvl[i]) begin
          if (cnt[i] == DB_LAST) begin
            lvl[i] <= sync_p1[i];
            evt[i] <= sync_p1[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + DB_ONE;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Mode FSM owning the target duty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm    <= MANUAL;
      target <= 8'd0;
      brc    <= '0;
    end else begin
      case (fsm)
        MANUAL: begin
          if (mode_s) begin
            fsm <= RISE;
            brc <= '0;
          end else if (evt[0] && !evt[1]) begin
            target <= inc_t;
          end else if (evt[1] && !evt[0]) begin
            target <= dec_t;
          end
        end
        RISE, FALL: begin
          if (!mode_s) begin
            fsm <= MANUAL;
            brc <= '0;
          end else if (period_start) begin
            if (brc == BR_LAST) begin
              brc <= '0;
              if (fsm == RISE) begin
                target <= inc_t;
                if (inc_t == 8'd255) fsm <= FALL;
              end else begin
                target <= dec_t;
                if (dec_t == 8'd0) fsm <= RISE;
              end
            end else begin
              brc <= brc + BR_ONE;
            end
          end
        end
        default: fsm <= MANUAL;
      endcase
    end
  end

  // Output stage: duty only follows target at a period boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty     <= 8'd0;
      duty_upd <= 1'b0;
    end else if (period_start) begin
      duty     <= target;
      duty_upd <= (target != duty);
    end else begin
      duty_upd <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: directed corner sequences, a vector table and
// randomized transactions compared against a transaction-level duty model.
module tb_pwm_duty_sequencer;

  localparam int OP_UP   = 0;
  localparam int OP_DN   = 1;
  localparam int OP_BOTH = 2;
  localparam int OP_PS   = 3;

  typedef struct {
    int op;
    int n;
    int exp_duty;
    int exp_upd;
    int exp_state;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_dn = 1'b0, mode_auto = 1'b0, period_start = 1'b0;
  logic [7:0] duty;
  logic       duty_upd;
  logic [1:0] state;

  logic       b_up = 1'b0, b_dn = 1'b0, b_mode = 1'b0, b_ps = 1'b0;
  logic [7:0] b_duty;
  logic       b_upd;
  logic [1:0] b_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pwm_duty_sequencer #(.DEBOUNCE_CYCLES(4), .STEP(16), .BREATHE_DIV(1)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .mode_auto(mode_auto),
    .period_start(period_start), .duty(duty), .duty_upd(duty_upd), .state(state)
  );

  pwm_duty_sequencer #(.DEBOUNCE_CYCLES(4), .STEP(64), .BREATHE_DIV(1)) dut64 (
    .clk(clk), .rst(rst), .btn_up(b_up), .btn_dn(b_dn), .mode_auto(b_mode),
    .period_start(b_ps), .duty(b_duty), .duty_upd(b_upd), .state(b_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic u, input logic d);
    btn_up = u;
    btn_dn = d;
    tick(12);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick(12);
  endtask

  task automatic ps_pulse();
    period_start = 1'b1;
    tick(1);
    period_start = 1'b0;
  endtask

  initial begin
    vec_t tbl[$];
    int   exp5[10] = '{0, 64, 128, 192, 255, 191, 127, 63, 0, 64};
    int   mt, md, mdir_up, k, e_upd;

    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_duty", duty, 0);
    chk("reset_upd", duty_upd, 0);
    chk("reset_state", state, 0);

    // bouncing button never reaches the debounce threshold
    for (int i = 0; i < 15; i++) begin
      btn_up = ~btn_up;
      tick(2);
    end
    btn_up = 1'b0;
    tick(12);
    ps_pulse();
    chk("bounce_duty", duty, 0);
    chk("bounce_upd", duty_upd, 0);

    // held button: one step, one update pulse
    btn_up = 1'b1;
    tick(12);
    ps_pulse();
    chk("held_duty", duty, 16);
    chk("held_upd_hi", duty_upd, 1);
    tick(1);
    chk("held_upd_lo", duty_upd, 0);
    tick(20);
    ps_pulse();
    chk("held_duty_again", duty, 16);
    chk("held_upd_again", duty_upd, 0);
    btn_up = 1'b0;
    tick(12);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_duty", duty, 0);
    chk("rst_mid_upd", duty_upd, 0);
    chk("rst_mid_state", state, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    ps_pulse();
    chk("post_rst_duty", duty, 0);
    chk("post_rst_upd", duty_upd, 0);

    tbl.push_back('{OP_PS,   1,   0, 0, 0});
    tbl.push_back('{OP_UP,   1,   0, 0, 0});
    tbl.push_back('{OP_PS,   1,  16, 1, 0});
    tbl.push_back('{OP_UP,  16,  16, 0, 0});
    tbl.push_back('{OP_PS,   1, 255, 1, 0});
    tbl.push_back('{OP_UP,   1, 255, 0, 0});
    tbl.push_back('{OP_PS,   1, 255, 0, 0});
    tbl.push_back('{OP_BOTH, 1, 255, 0, 0});
    tbl.push_back('{OP_PS,   1, 255, 0, 0});
    tbl.push_back('{OP_DN,   1, 255, 0, 0});
    tbl.push_back('{OP_PS,   1, 239, 1, 0});
    tbl.push_back('{OP_DN,  20, 239, 0, 0});
    tbl.push_back('{OP_PS,   1,   0, 1, 0});
    tbl.push_back('{OP_DN,   1,   0, 0, 0});
    tbl.push_back('{OP_PS,   1,   0, 0, 0});
    tbl.push_back('{OP_BOTH, 1,   0, 0, 0});
    tbl.push_back('{OP_PS,   1,   0, 0, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        case (tbl[i].op)
          OP_UP:   press(1'b1, 1'b0);
          OP_DN:   press(1'b0, 1'b1);
          OP_BOTH: press(1'b1, 1'b1);
          default: ps_pulse();
        endcase
      end
      chk($sformatf("tbl%0d_duty", i), duty, tbl[i].exp_duty);
      chk($sformatf("tbl%0d_upd", i), duty_upd, tbl[i].exp_upd);
      chk($sformatf("tbl%0d_state", i), state, tbl[i].exp_state);
    end

    // mode switch latency, ramp, ignored buttons, return to manual
    mode_auto = 1'b1;
    tick(2);
    chk("auto_lat_2", state, 0);
    tick(1);
    chk("auto_lat_3", state, 1);
    for (int i = 0; i < 8; i++) begin
      ps_pulse();
      chk($sformatf("ramp%0d_duty", i), duty, 16 * i);
      tick(3);
    end
    press(1'b1, 1'b0);
    chk("auto_btn_state", state, 1);
    mode_auto = 1'b0;
    tick(2);
    chk("man_lat_2", state, 1);
    tick(1);
    chk("man_lat_3", state, 0);
    ps_pulse();
    chk("man_duty128", duty, 128);
    chk("man_upd128", duty_upd, 1);
    ps_pulse();
    chk("man_hold128", duty, 128);
    chk("man_hold_upd", duty_upd, 0);
    press(1'b1, 1'b0);
    ps_pulse();
    chk("man_duty144", duty, 144);

    // breathing with STEP=64
    b_mode = 1'b1;
    tick(4);
    chk("b_state_rise", b_state, 1);
    mt = 0;
    mdir_up = 1;
    for (int i = 0; i < 10; i++) begin
      b_ps = 1'b1;
      tick(1);
      b_ps = 1'b0;
      chk($sformatf("breathe%0d_duty", i), b_duty, exp5[i]);
      if (mdir_up != 0) begin
        mt = (mt + 64 > 255) ? 255 : mt + 64;
        if (mt == 255) mdir_up = 0;
      end else begin
        mt = (mt < 64) ? 0 : mt - 64;
        if (mt == 0) mdir_up = 1;
      end
      chk($sformatf("breathe%0d_state", i), b_state, (mdir_up != 0) ? 1 : 2);
      tick(7);
    end
    b_mode = 1'b0;
    tick(4);

    // randomized transactions against a duty/target model
    mt = 144;
    md = 144;
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 5))
        0: begin
          press(1'b1, 1'b0);
          mt = (mt + 16 > 255) ? 255 : mt + 16;
        end
        1: begin
          press(1'b0, 1'b1);
          mt = (mt < 16) ? 0 : mt - 16;
        end
        2: press(1'b1, 1'b1);
        3: begin
          ps_pulse();
          e_upd = (mt != md) ? 1 : 0;
          md = mt;
          chk("rnd_ps_duty", duty, md);
          chk("rnd_ps_upd", duty_upd, e_upd);
        end
        4: begin
          mode_auto = 1'b1;
          tick(3);
          mdir_up = 1;
          k = $urandom_range(1, 6);
          for (int j = 0; j < k; j++) begin
            ps_pulse();
            e_upd = (mt != md) ? 1 : 0;
            md = mt;
            chk("rnd_auto_duty", duty, md);
            chk("rnd_auto_upd", duty_upd, e_upd);
            if (mdir_up != 0) begin
              mt = (mt + 16 > 255) ? 255 : mt + 16;
              if (mt == 255) mdir_up = 0;
            end else begin
              mt = (mt < 16) ? 0 : mt - 16;
              if (mt == 0) mdir_up = 1;
            end
            chk("rnd_auto_state", state, (mdir_up != 0) ? 1 : 2);
            tick($urandom_range(0, 3));
          end
          mode_auto = 1'b0;
          tick(3);
        end
        default: begin
          k = $urandom_range(2, 10);
          for (int j = 0; j < k; j++) begin
            if ($urandom_range(0, 1) == 0) btn_up = ~btn_up;
            else btn_dn = ~btn_dn;
            tick($urandom_range(1, 3));
            btn_up = 1'b0;
            btn_dn = 1'b0;
            tick($urandom_range(1, 3));
          end
          tick(12);
        end
      endcase
      chk("rnd_state", state, 0);
    end
    ps_pulse();
    chk("rnd_final_duty", duty, mt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
